// File: rtl/axi_wr_responder_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write master and axi_wr_responder.
interface axi_wr_responder_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 64
);
    logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [7:0]                s_axi_awlen;
    logic [2:0]                s_axi_awsize;
    logic [1:0]                s_axi_awburst;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;
    logic [DATA_WIDTH-1:0]     s_axi_wdata;
    logic [DATA_WIDTH/8-1:0]   s_axi_wstrb;
    logic                      s_axi_wlast;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;
    logic [1:0]                s_axi_bresp;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_bready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_bready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
    );
endinterface

// File: rtl/axi_wr_responder.sv
// AXI4 write slave terminating bursts into a word-addressed memory window, one burst at a time.
// Optional ready throttling by an 8-bit LFSR when AXI_WR_THROTTLE_EN is defined.
module axi_wr_responder #(
    parameter int                        DATA_WIDTH     = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        MEM_ADDR_WIDTH = 10,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
    parameter logic [7:0]                LFSR_SEED      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axi_wr_responder_if.slave         s_axi,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic                      burst_done
);
    localparam int         STRB_W  = DATA_WIDTH / 8;
    localparam int         BYTE_LG = $clog2(STRB_W);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_LG);
    // Decode arithmetic is widened so start + burst bytes and the window end never wrap.
    localparam int            WA     = AXI_ADDR_WIDTH + 18;
    localparam logic [WA-1:0] WIN_LO = WA'(BASE_ADDR);
    localparam logic [WA-1:0] WIN_HI = WIN_LO + (WA'(1) << (MEM_ADDR_WIDTH + BYTE_LG));

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } aw_req_t;

    state_t    state;
    aw_req_t   req;
    logic [7:0] beat_cnt;
    logic      err_dec, err_slv, err_last;
    logic      awready_q, wready_q, bvalid_q;
    logic [1:0] bresp_q;
    logic      throttle_ok;

`ifdef AXI_WR_THROTTLE_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign throttle_ok = lfsr[0];
`else
    assign throttle_ok = 1'b1;
`endif

    assign s_axi.s_axi_awready = awready_q & throttle_ok;
    assign s_axi.s_axi_wready  = wready_q & throttle_ok;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;

    logic aw_hs, w_hs, b_hs;
    assign aw_hs = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
    assign w_hs  = s_axi.s_axi_wvalid & s_axi.s_axi_wready;
    assign b_hs  = bvalid_q & s_axi.s_axi_bready;

    logic [WA-1:0] dec_start, dec_end;
    logic          dec_err, dec_slv;

    always_comb begin
        dec_start = WA'(s_axi.s_axi_awaddr);
        dec_end   = dec_start + ((WA'(s_axi.s_axi_awlen) + WA'(1)) << s_axi.s_axi_awsize) - WA'(1);
        dec_err   = (dec_start < WIN_LO) || (dec_end >= WIN_HI);
        // WRAP (10) and reserved (11) both have bit 1 set.
        dec_slv   = (s_axi.s_axi_awsize > MAX_SIZE) || s_axi.s_axi_awburst[1];
    end

    logic                      last_beat, last_bad;
    logic [AXI_ADDR_WIDTH-1:0] addr_step;

    assign last_beat = (beat_cnt == req.len);
    assign last_bad  = (s_axi.s_axi_wlast != last_beat);
    assign addr_step = AXI_ADDR_WIDTH'(1) << req.size;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= '0;
            beat_cnt   <= '0;
            err_dec    <= 1'b0;
            err_slv    <= 1'b0;
            err_last   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            burst_done <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            mem_we     <= 1'b0;
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                    if (aw_hs) begin
                        req.addr  <= s_axi.s_axi_awaddr;
                        req.len   <= s_axi.s_axi_awlen;
                        req.size  <= s_axi.s_axi_awsize;
                        req.burst <= s_axi.s_axi_awburst;
                        beat_cnt  <= '0;
                        err_dec   <= dec_err;
                        err_slv   <= dec_slv;
                        err_last  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // A wlast mismatch is reported but never blocks the write.
                        if (!err_dec && !err_slv) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= MEM_ADDR_WIDTH'((req.addr - BASE_ADDR) >> BYTE_LG);
                            mem_wdata <= s_axi.s_axi_wdata;
                            mem_wstrb <= s_axi.s_axi_wstrb;
                        end
                        if (req.burst == 2'b01) req.addr <= req.addr + addr_step;
                        if (last_bad) err_last <= 1'b1;
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            if (err_dec)                           bresp_q <= 2'b11;
                            else if (err_slv || err_last || last_bad) bresp_q <= 2'b10;
                            else                                   bresp_q <= 2'b00;
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= 2'b00;
                        burst_done <= 1'b1;
                        awready_q  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: expected writes and responses are queued as stimulus is driven.
module tb_axi_wr_responder;
    localparam int          DW   = 64;
    localparam int          AW   = 32;
    localparam int          MAW  = 10;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_wr_responder_if #(.AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [7:0]     mem_wstrb;
    logic           burst_done;

    axi_wr_responder #(
        .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW),
        .BASE_ADDR(BASE), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus.slave),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .burst_done(burst_done)
    );

    typedef struct packed {
        logic [MAW-1:0] a;
        logic [DW-1:0]  d;
        logic [7:0]     s;
    } wr_t;

    wr_t        wr_q[$];
    logic [1:0] resp_q[$];
    int total = 0, bad = 0, done_cnt = 0, exp_done = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every memory write and B handshake is matched against the queues.
    always @(negedge clk) begin
        if (burst_done) done_cnt++;
        if (mem_we) begin
            check("wr_pending", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(w.a));
                check("mem_wdata", mem_wdata, w.d);
                check("mem_wstrb", 64'(mem_wstrb), 64'(w.s));
            end
        end
        if (bus.s_axi_bvalid && bus.s_axi_bready) begin
            check("b_pending", 64'(resp_q.size() != 0), 64'd1);
            if (resp_q.size() != 0) check("bresp", 64'(bus.s_axi_bresp), 64'(resp_q.pop_front()));
        end
    end

    task automatic aw_send(logic [31:0] a, logic [7:0] len, logic [2:0] sz, logic [1:0] bt);
        int  n = 0;
        bit  hs;
        bus.s_axi_awaddr  = a;
        bus.s_axi_awlen   = len;
        bus.s_axi_awsize  = sz;
        bus.s_axi_awburst = bt;
        bus.s_axi_awvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = bus.s_axi_awready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        check("aw_handshake", 64'(hs), 64'd1);
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(logic [63:0] d, logic [7:0] s, bit last);
        int n = 0;
        bit hs;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        bus.s_axi_wlast  = last;
        bus.s_axi_wvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = bus.s_axi_wready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        check("w_handshake", 64'(hs), 64'd1);
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
    endtask

    // Drives one burst; the expected write address follows the AXI address rules independently.
    task automatic burst(logic [31:0] a, logic [7:0] len, logic [2:0] sz, logic [1:0] bt,
                         int last_at, logic [63:0] d0, logic [63:0] step, bit exp_wr, logic [1:0] resp);
        logic [31:0] cur = a;
        resp_q.push_back(resp);
        aw_send(a, len, sz, bt);
        for (int i = 0; i <= int'(len); i++) begin
            logic [63:0] d;
            logic [7:0]  s;
            d = d0 + step * 64'(i);
            s = 8'hF0 | 8'(i);
            if (exp_wr) wr_q.push_back('{a: MAW'((cur - BASE) >> 3), d: d, s: s});
            w_send(d, s, i == last_at);
            if (bt == 2'b01) cur = cur + (32'd1 << sz);
        end
    endtask

    task automatic wait_b(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_axi_bvalid && n < 200);
        check({tag, "_bvalid"}, 64'(bus.s_axi_bvalid), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_done++;
        check({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_wrq_empty"}, 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
        bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
                                  bus.s_axi_bresp, mem_we, burst_done}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_wready", 64'(bus.s_axi_wready), 64'd0);

        // 16-beat INCR burst of constant data
        burst(BASE, 8'd15, 3'd3, 2'b01, 15, 64'h25_0000_0025, 64'd0, 1'b1, 2'b00);
        wait_b("incr16");

        // Out-of-window start
        burst(32'h7000_0000, 8'd3, 3'd3, 2'b01, 3, 64'h1111, 64'd1, 1'b0, 2'b11);
        wait_b("oow");

        // Early wlast: writes still happen
        burst(BASE, 8'd3, 3'd3, 2'b01, 1, 64'hA000, 64'd3, 1'b1, 2'b10);
        wait_b("early_last");

        // FIXED burst hits word 8 three times
        burst(BASE + 32'h40, 8'd2, 3'd3, 2'b00, 2, 64'hB000, 64'd5, 1'b1, 2'b00);
        wait_b("fixed");

        // WRAP is unsupported
        burst(BASE, 8'd3, 3'd3, 2'b10, 3, 64'hC000, 64'd1, 1'b0, 2'b10);
        wait_b("wrap");

        // Last word of the window is legal; one beat past it is a decode error
        burst(BASE + 32'h1FF8, 8'd0, 3'd3, 2'b01, 0, 64'hD000, 64'd1, 1'b1, 2'b00);
        wait_b("edge_in");
        burst(BASE + 32'h1FF8, 8'd1, 3'd3, 2'b01, 1, 64'hD100, 64'd1, 1'b0, 2'b11);
        wait_b("edge_out");

        // Narrow INCR beats (4 bytes) advance the word address every other beat
        burst(BASE + 32'h20, 8'd3, 3'd2, 2'b01, 3, 64'hE000, 64'd1, 1'b1, 2'b00);
        wait_b("narrow");

        // B back-pressure with a pending AW
        bus.s_axi_bready = 1'b0;
        burst(32'h7000_0000, 8'd1, 3'd3, 2'b01, 1, 64'hF000, 64'd1, 1'b0, 2'b11);
        bus.s_axi_awaddr = BASE; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd3;
        bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
            check("bp_bresp", 64'(bus.s_axi_bresp), 64'd3);
            check("bp_awready", 64'(bus.s_axi_awready), 64'd0);
            @(posedge clk); #1;
        end
        bus.s_axi_bready = 1'b1;
        bus.s_axi_awvalid = 1'b0;
        wait_b("bp");
        burst(BASE + 32'h8, 8'd0, 3'd3, 2'b01, 0, 64'h1234, 64'd0, 1'b1, 2'b00);
        wait_b("after_bp");

        // Reset after beat 2 of an 8-beat burst: no B, no burst_done
        begin
            logic [31:0] cur = BASE + 32'h100;
            aw_send(cur, 8'd7, 3'd3, 2'b01);
            for (int i = 0; i < 3; i++) begin
                wr_q.push_back('{a: MAW'((cur - BASE) >> 3), d: 64'h5500 + 64'(i), s: 8'hFF});
                w_send(64'h5500 + 64'(i), 8'hFF, 1'b0);
                cur = cur + 32'd8;
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        check("rst_mid_mem_we", 64'(mem_we), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_awready", 64'(bus.s_axi_awready), 64'd1);
        check("rst_mid_wready", 64'(bus.s_axi_wready), 64'd0);
        check("rst_mid_done", 64'(done_cnt), 64'(exp_done));
        check("rst_mid_wrq", 64'(wr_q.size()), 64'd0);

        burst(BASE + 32'h10, 8'd1, 3'd3, 2'b01, 1, 64'h7700, 64'd9, 1'b1, 2'b00);
        wait_b("post_rst");
        check("resp_q_empty", 64'(resp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
